// File: rtl/conv2_pool_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv2_pool_sched_pkg
//  Brief    : Shared types, default dimensions and width helper for the
//             conv2 max-pool scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package conv2_pool_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_DONE    = 3'd4
   } sched_state_t;

   localparam int c_MAP_W    = 8;
   localparam int c_NUM_CH   = 8;
   localparam int c_READ_LAT = 2;

   // Bits needed to hold the values 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : conv2_pool_sched_pkg
`default_nettype wire

// File: rtl/conv2_pool_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv2_pool_sched_if
//  Brief    : Memory-read and pool-window handshake bundle between the
//             scheduler (master) and the conv2 memory / pool unit (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface conv2_pool_sched_if #(
   parameter int ADDR_W  = 6,
   parameter int OADDR_W = 4,
   parameter int CH_W    = 3
);
   logic               rd_en;
   logic [CH_W-1:0]    rd_ch;
   logic [ADDR_W-1:0]  addr0;
   logic [ADDR_W-1:0]  addr1;
   logic [ADDR_W-1:0]  addr2;
   logic [ADDR_W-1:0]  addr3;
   logic               win_valid;
   logic               win_ready;
   logic [OADDR_W-1:0] out_addr;

   modport master (
      output rd_en, rd_ch, addr0, addr1, addr2, addr3, win_valid, out_addr,
      input  win_ready
   );

   modport slave (
      input  rd_en, rd_ch, addr0, addr1, addr2, addr3, win_valid, out_addr,
      output win_ready
   );
endinterface : conv2_pool_sched_if
`default_nettype wire

// File: rtl/conv2_pool_sched_win_addr.sv
`default_nettype none
// ============================================================================
//  Module   : conv2_pool_sched_win_addr
//  Brief    : Combinational map from window (row, col) to the four source
//             addresses of the 2x2 window and the pooled output address.
//  Revision : 1.0  initial release
// ============================================================================
module conv2_pool_sched_win_addr #(
   parameter int MAP_W   = 8,
   parameter int WC_W    = 2,
   parameter int ADDR_W  = 6,
   parameter int OADDR_W = 4
) (
   input  logic [WC_W-1:0]    wr,
   input  logic [WC_W-1:0]    wc,
   output logic [ADDR_W-1:0]  addr0,
   output logic [ADDR_W-1:0]  addr1,
   output logic [ADDR_W-1:0]  addr2,
   output logic [ADDR_W-1:0]  addr3,
   output logic [OADDR_W-1:0] out_addr
);
   logic [ADDR_W-1:0] w_base;

   // Top-left pixel sits two map rows per window row and two pixels per window column in.
   always_comb begin
      w_base   = ADDR_W'(2 * MAP_W) * ADDR_W'(wr) + ADDR_W'(2) * ADDR_W'(wc);
      addr0    = w_base;
      addr1    = w_base + ADDR_W'(1);
      addr2    = w_base + ADDR_W'(MAP_W);
      addr3    = w_base + ADDR_W'(MAP_W + 1);
      out_addr = OADDR_W'(MAP_W / 2) * OADDR_W'(wr) + OADDR_W'(wc);
   end
endmodule : conv2_pool_sched_win_addr
`default_nettype wire

// File: rtl/conv2_pool_sched.sv
`default_nettype none
// ============================================================================
//  Module   : conv2_pool_sched
//  Brief    : Walks each conv2 channel in 2x2 windows, issues the window
//             reads, waits out memory latency and hands each window to the
//             max-pool unit over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module conv2_pool_sched
   import conv2_pool_sched_pkg::*;
#(
   parameter int MAP_W    = c_MAP_W,
   parameter int NUM_CH   = c_NUM_CH,
   parameter int READ_LAT = c_READ_LAT,
   parameter int ADDR_W   = 6,
   parameter int OADDR_W  = 4,
   parameter int CH_W     = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   conv2_pool_sched_if.master  bus
);
   localparam int                c_WC_W      = clog2_min1(MAP_W / 2);
   localparam int                c_WAIT_W    = clog2_min1(READ_LAT);
   localparam logic [c_WC_W-1:0] c_WIN_LAST  = c_WC_W'(MAP_W / 2 - 1);
   localparam logic [CH_W-1:0]   c_CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(READ_LAT - 1);

   sched_state_t        r_state;
   sched_state_t        w_next;
   logic [c_WAIT_W-1:0] r_wait;
   logic [c_WC_W-1:0]   r_wr, r_wc, w_wr_nxt, w_wc_nxt;
   logic [CH_W-1:0]     r_ch, w_ch_nxt;
   logic [ADDR_W-1:0]   r_addr0, r_addr1, r_addr2, r_addr3;
   logic [ADDR_W-1:0]   w_addr0, w_addr1, w_addr2, w_addr3;
   logic [OADDR_W-1:0]  r_oaddr, w_oaddr;
   logic                w_start_ok, w_hs, w_last, w_load;

   assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_hs       = (r_state == S_PRESENT) && bus.win_ready;
   assign w_last     = (r_wr == c_WIN_LAST) && (r_wc == c_WIN_LAST) && (r_ch == c_CH_LAST);
   assign w_load     = w_start_ok || w_hs;

   // Window counters after this cycle: cleared on start, stepped row-major on a handshake.
   always_comb begin
      w_wr_nxt = r_wr;
      w_wc_nxt = r_wc;
      w_ch_nxt = r_ch;
      if (w_start_ok) begin
         w_wr_nxt = '0;
         w_wc_nxt = '0;
         w_ch_nxt = '0;
      end else if (w_hs) begin
         if (r_wc == c_WIN_LAST) begin
            w_wc_nxt = '0;
            if (r_wr == c_WIN_LAST) begin
               w_wr_nxt = '0;
               w_ch_nxt = (r_ch == c_CH_LAST) ? '0 : r_ch + CH_W'(1);
            end else begin
               w_wr_nxt = r_wr + c_WC_W'(1);
            end
         end else begin
            w_wc_nxt = r_wc + c_WC_W'(1);
         end
      end
   end

   conv2_pool_sched_win_addr #(
      .MAP_W   (MAP_W),
      .WC_W    (c_WC_W),
      .ADDR_W  (ADDR_W),
      .OADDR_W (OADDR_W)
   ) u_win_addr (
      .wr       (w_wr_nxt),
      .wc       (w_wc_nxt),
      .addr0    (w_addr0),
      .addr1    (w_addr1),
      .addr2    (w_addr2),
      .addr3    (w_addr3),
      .out_addr (w_oaddr)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_ISSUE;
         S_ISSUE:   w_next = S_WAIT;
         S_WAIT:    if (r_wait == '0) w_next = S_PRESENT;
         S_PRESENT: if (bus.win_ready) w_next = w_last ? S_DONE : S_ISSUE;
         S_DONE:    if (start) w_next = S_ISSUE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Latency counter: loaded in ISSUE so WAIT lasts exactly READ_LAT cycles.
   always_ff @(posedge clk) begin
      if (reset)                                  r_wait <= '0;
      else if (r_state == S_ISSUE)                r_wait <= c_WAIT_LOAD;
      else if (r_state == S_WAIT && r_wait != '0) r_wait <= r_wait - c_WAIT_W'(1);
   end

   // Counters and window addresses move together, only on start or handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_wc    <= '0;
         r_ch    <= '0;
         r_addr0 <= '0;
         r_addr1 <= '0;
         r_addr2 <= '0;
         r_addr3 <= '0;
         r_oaddr <= '0;
      end else if (w_load) begin
         r_wr    <= w_wr_nxt;
         r_wc    <= w_wc_nxt;
         r_ch    <= w_ch_nxt;
         r_addr0 <= w_addr0;
         r_addr1 <= w_addr1;
         r_addr2 <= w_addr2;
         r_addr3 <= w_addr3;
         r_oaddr <= w_oaddr;
      end
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      bus.rd_en     = (r_state == S_ISSUE);
      bus.win_valid = (r_state == S_PRESENT);
      busy          = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_PRESENT);
      done          = (r_state == S_DONE);
      bus.rd_ch     = r_ch;
      bus.addr0     = r_addr0;
      bus.addr1     = r_addr1;
      bus.addr2     = r_addr2;
      bus.addr3     = r_addr3;
      bus.out_addr  = r_oaddr;
   end
endmodule : conv2_pool_sched
`default_nettype wire

// File: tb/tb_conv2_pool_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv2_pool_sched
//  Brief    : Scoreboard bench for conv2_pool_sched (8x8 map, 8 channels,
//             read latency 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv2_pool_sched;
   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy;
   logic done;

   conv2_pool_sched_if #(.ADDR_W(6), .OADDR_W(4), .CH_W(3)) bus ();

   conv2_pool_sched #(
      .MAP_W(8), .NUM_CH(8), .READ_LAT(2), .ADDR_W(6), .OADDR_W(4), .CH_W(3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] ch;
      logic [5:0] a0;
      logic [5:0] a1;
      logic [5:0] a2;
      logic [5:0] a3;
      logic [3:0] oa;
   } win_t;

   win_t exp_q[$];
   int   checks   = 0;
   int   passes   = 0;
   int   hs_total = 0;
   int   base     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic win_t cur_win();
      win_t w;
      w = '{ch: bus.rd_ch, a0: bus.addr0, a1: bus.addr1, a2: bus.addr2,
            a3: bus.addr3, oa: bus.out_addr};
      return w;
   endfunction

   // Expected window sequence of one full pass, hand formula per window.
   task automatic push_pass();
      win_t w;
      for (int ch = 0; ch < 8; ch++)
         for (int wr = 0; wr < 4; wr++)
            for (int wc = 0; wc < 4; wc++) begin
               w.ch = 3'(ch);
               w.a0 = 6'(16 * wr + 2 * wc);
               w.a1 = 6'(16 * wr + 2 * wc + 1);
               w.a2 = 6'(16 * wr + 2 * wc + 8);
               w.a3 = 6'(16 * wr + 2 * wc + 9);
               w.oa = 4'(4 * wr + wc);
               exp_q.push_back(w);
            end
   endtask

   // Monitor: every issue must match the head window; every handshake consumes it.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rd_en) begin
            if (exp_q.size() == 0) chk("issue_unexpected", 64'd1, 64'd0);
            else                   chk("issue_window", 64'(cur_win()), 64'(exp_q[0]));
         end
         if (bus.win_valid && bus.win_ready) begin
            if (exp_q.size() == 0) chk("present_unexpected", 64'd1, 64'd0);
            else                   chk("present_window", 64'(cur_win()), 64'(exp_q.pop_front()));
            hs_total++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_hs(input int n);
      int k = 0;
      while ((hs_total - base) < n && k < 4000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk($sformatf("reach_hs_%0d", n), 64'((hs_total - base) >= n), 64'd1);
   endtask

   task automatic wait_rd();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.rd_en && k < 100);
      chk("rd_en_seen", 64'(bus.rd_en), 64'd1);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", 64'(done), 64'd1);
   endtask

   function automatic logic [36:0] all_outs();
      return {bus.rd_en, bus.win_valid, busy, done, bus.rd_ch,
              bus.addr0, bus.addr1, bus.addr2, bus.addr3, bus.out_addr};
   endfunction

   initial begin
      int n;
      reset         = 1'b1;
      start         = 1'b0;
      bus.win_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_outputs", 64'(all_outs()), 64'd0);

      // Pass 1: first-window timing, addressing boundaries, stall, ignored start.
      base = hs_total;
      push_pass();
      tick();
      pulse_start();
      @(negedge clk);
      chk("c1_rd_en", 64'(bus.rd_en), 64'd1);
      chk("c1_addr", 64'({bus.addr0, bus.addr1, bus.addr2, bus.addr3}),
          64'({6'd0, 6'd1, 6'd8, 6'd9}));
      chk("c1_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("c2_rd_valid", 64'({bus.rd_en, bus.win_valid}), 64'd0);
      @(negedge clk);
      chk("c3_rd_valid", 64'({bus.rd_en, bus.win_valid}), 64'd0);
      @(negedge clk);
      chk("c4_valid", 64'(bus.win_valid), 64'd1);
      @(negedge clk);
      chk("c5_rd_en", 64'(bus.rd_en), 64'd1);
      chk("c5_addr", 64'({bus.addr0, bus.addr1, bus.addr2, bus.addr3, bus.out_addr}),
          64'({6'd2, 6'd3, 6'd10, 6'd11, 4'd1}));

      wait_hs(4);
      wait_rd();
      chk("win4_addr", 64'({bus.addr0, bus.addr1, bus.addr2, bus.addr3, bus.out_addr}),
          64'({6'd16, 6'd17, 6'd24, 6'd25, 4'd4}));
      wait_hs(15);
      wait_rd();
      chk("win15_addr", 64'(cur_win()),
          64'({3'd0, 6'd54, 6'd55, 6'd62, 6'd63, 4'd15}));
      wait_hs(16);
      wait_rd();
      chk("ch1_win0", 64'(cur_win()), 64'({3'd1, 6'd0, 6'd1, 6'd8, 6'd9, 4'd0}));

      // Stall the pool unit on window 4 of channel 1.
      wait_hs(20);
      tick();
      bus.win_ready = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.win_valid && n < 20);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 64'(bus.win_valid), 64'd1);
         chk("stall_no_rd", 64'(bus.rd_en), 64'd0);
         chk("stall_addr", 64'(cur_win()), 64'({3'd1, 6'd16, 6'd17, 6'd24, 6'd25, 4'd4}));
         chk("stall_hs", 64'(hs_total - base), 64'd20);
         if (i < 4) @(negedge clk);
      end
      tick();
      bus.win_ready = 1'b1;
      wait_hs(21);
      wait_rd();
      chk("post_stall_addr", 64'(cur_win()), 64'({3'd1, 6'd18, 6'd19, 6'd26, 6'd27, 4'd5}));
      chk("single_advance", 64'(hs_total - base), 64'd21);

      // Start pulses while busy must not disturb the sequence.
      wait_hs(30);
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      wait_done();
      #1;
      chk("pass1_hs", 64'(hs_total - base), 64'd128);
      chk("pass1_queue", 64'(exp_q.size()), 64'd0);
      chk("pass1_busy", 64'(busy), 64'd0);

      // Pass 2 from DONE: full-pass latency with win_ready high throughout.
      base = hs_total;
      push_pass();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) chk("restart_done_drop", 64'({bus.rd_en, done}), 64'b10);
      end while (!done && n < 2000);
      chk("pass2_latency", 64'(n), 64'd513);
      #1;
      chk("pass2_hs", 64'(hs_total - base), 64'd128);
      chk("pass2_queue", 64'(exp_q.size()), 64'd0);

      // Pass 3: abort with reset while waiting on a channel-3 read.
      base = hs_total;
      push_pass();
      tick();
      pulse_start();
      wait_hs(50);
      wait_rd();
      chk("ch3_issue", 64'(bus.rd_ch), 64'd3);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("in_wait", 64'({busy, bus.rd_en, bus.win_valid}), 64'b100);
      tick();
      @(negedge clk);
      chk("abort_outputs", 64'(all_outs()), 64'd0);
      exp_q.delete();
      tick();
      reset = 1'b0;
      base = hs_total;
      push_pass();
      pulse_start();
      @(negedge clk);
      chk("restart_win0", 64'({bus.rd_en, cur_win()}),
          64'({1'b1, 3'd0, 6'd0, 6'd1, 6'd8, 6'd9, 4'd0}));
      wait_done();
      #1;
      chk("pass3_hs", 64'(hs_total - base), 64'd128);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule : tb_conv2_pool_sched
`default_nettype wire
